puf_cmd_rx: RTL and testbench
=============================

Name: puf_cmd_rx

Overview:
Downstream consumer of the UART byte receiver. Assembles framed command packets from the received byte stream: SYNC, CMD, CHAL_BYTES payload bytes, XOR checksum. Validates each frame and presents the command code and challenge vector to the RO-PUF controller, holding them until the controller acknowledges. Reports checksum, inter-byte timeout and overrun errors as one-cycle pulses with a code.

Parameters:
CHAL_BYTES, 4, number of payload (challenge) bytes per frame; legal range 1..16.
TIMEOUT_CLKS, 100000, maximum i_Clock cycles allowed between bytes inside a frame; minimum 2.
SYNC_BYTE, 8'hA5, frame start marker.

Ports:
i_Clock  input  1  system clock, same domain as the UART receiver.
i_Reset  input  1  synchronous, active-high reset.
i_Rx_DV  input  1  one-cycle strobe: i_Rx_Byte is valid.
i_Rx_Byte  input  8  received byte.
o_Cmd_Valid  output  1  frame accepted; o_Cmd and o_Challenge are valid and stable while high.
o_Cmd  output  8  command code of the accepted frame.
o_Challenge  output  CHAL_BYTES*8  payload; the first received payload byte occupies the MSBs.
i_Cmd_Ack  input  1  controller consumed the command; sampled only while o_Cmd_Valid is high.
o_Err  output  1  one-cycle error pulse.
o_Err_Code  output  2  01 = bad checksum, 10 = timeout, 11 = overrun. Valid while o_Err is high; holds its last value otherwise.

Behaviour:
- Reset (synchronous, i_Reset=1 at the clock edge): state S_IDLE; o_Cmd_Valid=0, o_Err=0, o_Err_Code=0, o_Cmd=0, o_Challenge=0; running checksum, byte counter and timeout counter cleared. Reset mid-frame or during S_HOLD discards everything.
- States:
  - S_IDLE: on DV with byte==SYNC_BYTE, go to S_CMD and clear the checksum. Any other byte is discarded silently, with no error.
  - S_CMD: on DV, latch the byte into the CMD shadow, checksum = byte, byte counter = 0, go to S_PAYLOAD.
  - S_PAYLOAD: on DV, shift the byte into the challenge shadow (shift left by 8, new byte in the LSBs) and XOR it into the checksum. After the CHAL_BYTES-th byte, go to S_CSUM.
  - S_CSUM: on DV, compare the byte with the checksum.
    - Equal: copy the shadows to o_Cmd/o_Challenge, set o_Cmd_Valid=1, go to S_HOLD.
    - Not equal: pulse o_Err with code 01, go to S_IDLE. o_Cmd/o_Challenge are unchanged.
  - S_HOLD: o_Cmd_Valid stays high and the outputs are stable. i_Cmd_Ack=1 clears o_Cmd_Valid on the next edge and returns to S_IDLE.
- Latency: o_Cmd_Valid rises on the edge following the clock in which the checksum byte's DV is high.
- Timeout: the counter runs in S_CMD, S_PAYLOAD and S_CSUM and is cleared on every DV and on entering S_CMD. When it reaches TIMEOUT_CLKS-1 without a DV, pulse o_Err with code 10 and go to S_IDLE. A DV in the same cycle as the terminal count wins: the byte is accepted and there is no timeout. The counter is held at 0 in S_IDLE and S_HOLD.
- Overrun: a DV in S_HOLD without i_Cmd_Ack pulses o_Err with code 11. The byte is dropped and the state stays S_HOLD.
- DV and i_Cmd_Ack in the same cycle in S_HOLD: no overrun. The frame is released, and the byte is processed as in S_IDLE, so SYNC_BYTE goes directly to S_CMD.
- i_Cmd_Ack outside S_HOLD is ignored.
- o_Err never pulses on two consecutive cycles; each error event produces exactly one pulse.
- Widths: byte counter is $clog2(CHAL_BYTES+1) bits; timeout counter is $clog2(TIMEOUT_CLKS) bits. No arithmetic overflow is possible within these ranges.

Decomposition:
- Package puf_cmd_pkg: state encoding (S_IDLE, S_CMD, S_PAYLOAD, S_CSUM, S_HOLD, 3 bits), error codes (ERR_CSUM=2'b01, ERR_TIMEOUT=2'b10, ERR_OVERRUN=2'b11), default SYNC_BYTE value.
- Single module. No sub-module is needed; the timeout counter stays inline.

Test Plan:
- Good frame A5 01 DE AD BE EF 23 (CHAL_BYTES=4) -> o_Cmd_Valid=1 one cycle after the last DV, o_Cmd=8'h01, o_Challenge=32'hDEADBEEF, o_Err never asserted; o_Cmd_Valid holds until i_Cmd_Ack, then falls on the next edge.
- Same frame with checksum 24 -> single o_Err pulse with code 01, o_Cmd_Valid stays 0, the next good frame is accepted normally.
- A5 01 DE, then no byte for TIMEOUT_CLKS cycles (bench TIMEOUT_CLKS=50) -> o_Err with code 10 exactly 50 cycles after the last DV, state S_IDLE. A byte on cycle 49 instead produces no error.
- Leading garbage 00 FF 5A, then a good frame -> no errors, the frame is accepted.
- In S_HOLD, send byte 11 without ack -> o_Err with code 11, and o_Cmd/o_Challenge are unchanged. Then send ack and A5 in the same cycle -> no error, o_Cmd_Valid drops, and the following 01 DE AD BE EF 23 yields a new valid command.
- Assert i_Reset after A5 01 DE -> all outputs 0; a subsequent full good frame is accepted.

Source files
------------

// File: rtl/puf_cmd_pkg.sv
// Shared definitions for the PUF command receiver.
// Contents: the receiver FSM state encoding (3 bits), the error codes
// reported on o_Err_Code, and the default frame start marker.
package puf_cmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CSUM    = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/puf_cmd_rx.sv
// puf_cmd_rx: assembles framed commands from the UART byte stream.
// Frame layout: SYNC, CMD, CHAL_BYTES payload bytes, XOR checksum
// (CMD ^ all payload bytes). Accepted frames are presented on
// o_Cmd/o_Challenge with o_Cmd_Valid held until i_Cmd_Ack.
// Ports:
//   i_Clock, i_Reset     clock, synchronous active-high reset
//   i_Rx_DV, i_Rx_Byte   byte strobe and data from the UART receiver
//   o_Cmd_Valid          accepted command is present and stable
//   o_Cmd, o_Challenge   command code, payload (first byte in MSBs)
//   i_Cmd_Ack            consumer releases the held command
//   o_Err, o_Err_Code    one-cycle error pulse; code holds between pulses
module puf_cmd_rx
  import puf_cmd_pkg::*;
#(
  parameter int         CHAL_BYTES   = 4,
  parameter int         TIMEOUT_CLKS = 100000,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic                    i_Clock,
  input  logic                    i_Reset,
  input  logic                    i_Rx_DV,
  input  logic [7:0]              i_Rx_Byte,
  output logic                    o_Cmd_Valid,
  output logic [7:0]              o_Cmd,
  output logic [CHAL_BYTES*8-1:0] o_Challenge,
  input  logic                    i_Cmd_Ack,
  output logic                    o_Err,
  output logic [1:0]              o_Err_Code
);

  localparam int CW = CHAL_BYTES * 8;
  localparam int BW = $clog2(CHAL_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT_CLKS);

  state_t          state;
  logic [7:0]      csum;
  logic [7:0]      cmd_sh;
  logic [CW-1:0]   chal_sh;
  logic [BW-1:0]   byte_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic            in_frame;
  logic            tmo_hit;
  logic            is_sync;

  always_comb begin
    in_frame = (state == S_CMD) || (state == S_PAYLOAD) || (state == S_CSUM);
    // A DV on the terminal count takes priority over the timeout.
    tmo_hit  = in_frame && !i_Rx_DV && (tmo_cnt == TW'(TIMEOUT_CLKS - 1));
    is_sync  = i_Rx_DV && (i_Rx_Byte == SYNC_BYTE);
  end

  // Inter-byte timer: idle outside a frame, restarted by every byte.
  always_ff @(posedge i_Clock) begin
    if (i_Reset || !in_frame || i_Rx_DV || tmo_hit)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state       <= S_IDLE;
      csum        <= '0;
      cmd_sh      <= '0;
      chal_sh     <= '0;
      byte_cnt    <= '0;
      o_Cmd_Valid <= 1'b0;
      o_Cmd       <= '0;
      o_Challenge <= '0;
      o_Err       <= 1'b0;
      o_Err_Code  <= '0;
    end else begin
      o_Err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (is_sync) begin
            state <= S_CMD;
            csum  <= '0;
          end
        end
        S_CMD: begin
          if (i_Rx_DV) begin
            cmd_sh   <= i_Rx_Byte;
            csum     <= i_Rx_Byte;
            byte_cnt <= '0;
            state    <= S_PAYLOAD;
          end else if (tmo_hit) begin
            o_Err      <= 1'b1;
            o_Err_Code <= ERR_TIMEOUT;
            state      <= S_IDLE;
          end
        end
        S_PAYLOAD: begin
          if (i_Rx_DV) begin
            chal_sh  <= (chal_sh << 8) | CW'(i_Rx_Byte);
            csum     <= csum ^ i_Rx_Byte;
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == BW'(CHAL_BYTES - 1))
              state <= S_CSUM;
          end else if (tmo_hit) begin
            o_Err      <= 1'b1;
            o_Err_Code <= ERR_TIMEOUT;
            state      <= S_IDLE;
          end
        end
        S_CSUM: begin
          if (i_Rx_DV) begin
            if (i_Rx_Byte == csum) begin
              o_Cmd       <= cmd_sh;
              o_Challenge <= chal_sh;
              o_Cmd_Valid <= 1'b1;
              state       <= S_HOLD;
            end else begin
              o_Err      <= 1'b1;
              o_Err_Code <= ERR_CSUM;
              state      <= S_IDLE;
            end
          end else if (tmo_hit) begin
            o_Err      <= 1'b1;
            o_Err_Code <= ERR_TIMEOUT;
            state      <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (i_Cmd_Ack) begin
            // Release and treat a coincident byte as if already idle.
            o_Cmd_Valid <= 1'b0;
            if (is_sync) begin
              state <= S_CMD;
              csum  <= '0;
            end else begin
              state <= S_IDLE;
            end
          end else if (i_Rx_DV) begin
            o_Err      <= 1'b1;
            o_Err_Code <= ERR_OVERRUN;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_cmd_rx.sv
module tb_puf_cmd_rx;

  localparam int CHAL_BYTES   = 4;
  localparam int TIMEOUT_CLKS = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dv = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        ack = 1'b0;
  logic        cmd_valid;
  logic [7:0]  cmd;
  logic [31:0] chal;
  logic        err;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int exp_err = 0;
  int tmo_early;

  puf_cmd_rx #(
    .CHAL_BYTES  (CHAL_BYTES),
    .TIMEOUT_CLKS(TIMEOUT_CLKS),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .i_Clock    (clk),
    .i_Reset    (rst),
    .i_Rx_DV    (dv),
    .i_Rx_Byte  (rx_byte),
    .o_Cmd_Valid(cmd_valid),
    .o_Cmd      (cmd),
    .o_Challenge(chal),
    .i_Cmd_Ack  (ack),
    .o_Err      (err),
    .o_Err_Code (err_code)
  );

  always #5 clk = ~clk;

  // Count every cycle in which the error pulse is high.
  always @(negedge clk) if (err === 1'b1) err_seen++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; byte is sampled on the next posedge, returns at the following negedge.
  task automatic send_byte(input logic [7:0] b);
    dv = 1'b1;
    rx_byte = b;
    @(negedge clk);
    dv = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [31:0] p, input logic [7:0] cs);
    send_byte(8'hA5);
    send_byte(c);
    send_byte(p[31:24]);
    send_byte(p[23:16]);
    send_byte(p[15:8]);
    send_byte(p[7:0]);
    send_byte(cs);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_valid", cmd_valid, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_code", err_code, 2'b00);
    check("rst_cmd", cmd, 8'h00);
    check("rst_chal", chal, 32'h0);

    // Good frame with latency check
    send_byte(8'hA5); send_byte(8'h01);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    check("good_valid_before_csum", cmd_valid, 1'b0);
    send_byte(8'h23);
    check("good_valid", cmd_valid, 1'b1);
    check("good_cmd", cmd, 8'h01);
    check("good_chal", chal, 32'hDEADBEEF);
    repeat (3) @(negedge clk);
    check("good_hold_valid", cmd_valid, 1'b1);
    check("good_hold_chal", chal, 32'hDEADBEEF);
    do_ack();
    check("good_ack_valid", cmd_valid, 1'b0);
    check("good_no_err", err_seen, exp_err);

    // Bad checksum
    send_frame(8'h01, 32'hDEADBEEF, 8'h24);
    exp_err++;
    check("bad_err", err, 1'b1);
    check("bad_code", err_code, 2'b01);
    check("bad_valid", cmd_valid, 1'b0);
    check("bad_cmd_unchanged", cmd, 8'h01);
    @(negedge clk);
    check("bad_err_one_cycle", err, 1'b0);
    check("bad_code_holds", err_code, 2'b01);
    check("bad_err_count", err_seen, exp_err);
    send_frame(8'h02, 32'h11223344, 8'h46);
    check("after_bad_valid", cmd_valid, 1'b1);
    check("after_bad_cmd", cmd, 8'h02);
    check("after_bad_chal", chal, 32'h11223344);
    do_ack();

    // Timeout: error exactly TIMEOUT_CLKS cycles after the last byte
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'hDE);
    tmo_early = 0;
    for (int k = 1; k < TIMEOUT_CLKS; k++) begin
      @(negedge clk);
      if (err === 1'b1) tmo_early++;
    end
    check("tmo_no_early_err", tmo_early, 0);
    @(negedge clk);
    exp_err++;
    check("tmo_err", err, 1'b1);
    check("tmo_code", err_code, 2'b10);
    @(negedge clk);
    check("tmo_err_one_cycle", err, 1'b0);
    send_frame(8'h01, 32'hDEADBEEF, 8'h23);
    check("tmo_idle_then_valid", cmd_valid, 1'b1);
    check("tmo_idle_then_chal", chal, 32'hDEADBEEF);
    check("tmo_err_count", err_seen, exp_err);
    do_ack();

    // Byte arriving on the terminal count is accepted
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'hDE);
    repeat (TIMEOUT_CLKS - 1) @(negedge clk);
    send_byte(8'hAD);
    send_byte(8'hBE); send_byte(8'hEF); send_byte(8'h23);
    check("tmo_edge_no_err", err_seen, exp_err);
    check("tmo_edge_valid", cmd_valid, 1'b1);
    check("tmo_edge_chal", chal, 32'hDEADBEEF);
    do_ack();

    // Leading garbage then a good frame
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    send_frame(8'h03, 32'h01020304, 8'h07);
    check("garb_valid", cmd_valid, 1'b1);
    check("garb_cmd", cmd, 8'h03);
    check("garb_chal", chal, 32'h01020304);
    check("garb_no_err", err_seen, exp_err);

    // Overrun while holding
    send_byte(8'h11);
    exp_err++;
    check("ovr_err", err, 1'b1);
    check("ovr_code", err_code, 2'b11);
    check("ovr_valid", cmd_valid, 1'b1);
    check("ovr_cmd", cmd, 8'h03);
    check("ovr_chal", chal, 32'h01020304);

    // Ack together with SYNC: release and start a new frame directly
    ack = 1'b1; dv = 1'b1; rx_byte = 8'hA5;
    @(negedge clk);
    ack = 1'b0; dv = 1'b0;
    check("ackdv_valid", cmd_valid, 1'b0);
    check("ackdv_no_err", err, 1'b0);
    send_byte(8'h01);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    send_byte(8'h23);
    check("ackdv_new_valid", cmd_valid, 1'b1);
    check("ackdv_new_cmd", cmd, 8'h01);
    check("ackdv_new_chal", chal, 32'hDEADBEEF);
    check("ackdv_err_count", err_seen, exp_err);
    do_ack();

    // Reset mid-frame
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'hDE);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_valid", cmd_valid, 1'b0);
    check("mrst_err", err, 1'b0);
    check("mrst_code", err_code, 2'b00);
    check("mrst_cmd", cmd, 8'h00);
    check("mrst_chal", chal, 32'h0);
    send_frame(8'h02, 32'h11223344, 8'h46);
    check("mrst_new_valid", cmd_valid, 1'b1);
    check("mrst_new_cmd", cmd, 8'h02);
    check("mrst_new_chal", chal, 32'h11223344);
    check("mrst_err_count", err_seen, exp_err);
    do_ack();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
